div_sequencer: RTL and testbench

//  Issue/retire stage between execute and the iterative divider (div).

---
 rtl/div_sequencer.sv | 153 +++++++++++++++
 tb/tb_div_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Issue/retire sequencer for the iterative divider: accepts DIV/DIVU/REM/REMU requests,
// drives and holds the divider operands, and keeps a one-entry quotient/remainder cache.
module div_sequencer #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [1:0]   req_op_i,
  input  logic [N-1:0] req_a_i,
  input  logic [N-1:0] req_b_i,
  input  logic         flush_i,
  output logic         resp_valid_o,
  input  logic         resp_ready_i,
  output logic [N-1:0] resp_data_o,
  output logic         div_enable_o,
  output logic         div_signed_o,
  output logic [N-1:0] div_a_o,
  output logic [N-1:0] div_b_o,
  input  logic         div_hold_i,
  input  logic [N-1:0] div_quo_i,
  input  logic [N-1:0] div_rem_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] div_a_q, div_a_d, div_b_q, div_b_d;
  logic         div_signed_q, div_signed_d;
  logic         op_rem_q, op_rem_d;
  logic [N-1:0] resp_data_q, resp_data_d;
  logic         kill_q, kill_d;
  logic         cache_valid_q, cache_valid_d;
  logic         cache_signed_q, cache_signed_d;
  logic [N-1:0] cache_a_q, cache_a_d, cache_b_q, cache_b_d;
  logic [N-1:0] cache_quo_q, cache_quo_d, cache_rem_q, cache_rem_d;

  logic         req_signed, hit;
  logic [N-1:0] hit_data, div_sel;

  assign req_signed = ~req_op_i[0];
  assign hit        = cache_valid_q && (cache_a_q == req_a_i) && (cache_b_q == req_b_i) &&
                      (cache_signed_q == req_signed);
  assign hit_data   = req_op_i[1] ? cache_rem_q : cache_quo_q;
  assign div_sel    = op_rem_q ? div_rem_i : div_quo_i;

  always_comb begin
    state_d        = state_q;
    div_a_d        = div_a_q;
    div_b_d        = div_b_q;
    div_signed_d   = div_signed_q;
    op_rem_d       = op_rem_q;
    resp_data_d    = resp_data_q;
    kill_d         = kill_q;
    cache_valid_d  = cache_valid_q;
    cache_signed_d = cache_signed_q;
    cache_a_d      = cache_a_q;
    cache_b_d      = cache_b_q;
    cache_quo_d    = cache_quo_q;
    cache_rem_d    = cache_rem_q;
    req_ready_o    = 1'b0;
    resp_valid_o   = 1'b0;
    div_enable_o   = 1'b0;

    case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          if (hit) begin
            resp_data_d = hit_data;
            state_d     = StDone;
          end else begin
            div_a_d      = req_a_i;
            div_b_d      = req_b_i;
            div_signed_d = req_signed;
            op_rem_d     = req_op_i[1];
            kill_d       = 1'b0;
            state_d      = StIssue;
          end
        end
      end
      StIssue: begin
        div_enable_o = 1'b1;
        if (flush_i) kill_d = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        div_enable_o = 1'b1;
        if (flush_i) kill_d = 1'b1;
        if (!div_hold_i) begin
          // A killed result still fills the cache; only the response is dropped.
          cache_valid_d  = 1'b1;
          cache_a_d      = div_a_q;
          cache_b_d      = div_b_q;
          cache_signed_d = div_signed_q;
          cache_quo_d    = div_quo_i;
          cache_rem_d    = div_rem_i;
          if (kill_q || flush_i) begin
            kill_d  = 1'b0;
            state_d = StIdle;
          end else begin
            resp_data_d = div_sel;
            state_d     = StDone;
          end
        end
      end
      StDone: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i || flush_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      div_a_q        <= '0;
      div_b_q        <= '0;
      div_signed_q   <= 1'b0;
      op_rem_q       <= 1'b0;
      resp_data_q    <= '0;
      kill_q         <= 1'b0;
      cache_valid_q  <= 1'b0;
      cache_signed_q <= 1'b0;
      cache_a_q      <= '0;
      cache_b_q      <= '0;
      cache_quo_q    <= '0;
      cache_rem_q    <= '0;
    end else begin
      state_q        <= state_d;
      div_a_q        <= div_a_d;
      div_b_q        <= div_b_d;
      div_signed_q   <= div_signed_d;
      op_rem_q       <= op_rem_d;
      resp_data_q    <= resp_data_d;
      kill_q         <= kill_d;
      cache_valid_q  <= cache_valid_d;
      cache_signed_q <= cache_signed_d;
      cache_a_q      <= cache_a_d;
      cache_b_q      <= cache_b_d;
      cache_quo_q    <= cache_quo_d;
      cache_rem_q    <= cache_rem_d;
    end
  end

  assign resp_data_o  = resp_data_q;
  assign div_signed_o = div_signed_q;
  assign div_a_o      = div_a_q;
  assign div_b_o      = div_b_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a cycle-timed behavioural stand-in for the divider.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        div_enable, div_signed, div_hold;
  logic [31:0] div_a, div_b, div_quo, div_rem;

  int vectors = 0;
  int miscompares = 0;
  int en_cnt = 0;
  int stab_errs = 0;

  always #5 clk = ~clk;

  div_sequencer #(.N(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .flush_i     (flush),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_data_o (resp_data),
    .div_enable_o(div_enable),
    .div_signed_o(div_signed),
    .div_a_o     (div_a),
    .div_b_o     (div_b),
    .div_hold_i  (div_hold),
    .div_quo_i   (div_quo),
    .div_rem_i   (div_rem)
  );

  // Divider stand-in: enable high in cycle 1 -> hold drops at cycle 36 (or 2 on fast paths).
  logic [5:0] dcnt;
  logic       fast;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) dcnt <= '0;
    else if (!div_enable) dcnt <= '0;
    else if (dcnt != 6'd63) dcnt <= dcnt + 6'd1;
  end

  assign fast = (div_b == 32'd0) || (div_b == 32'd1) ||
                (div_signed && div_a == 32'h8000_0000 && div_b == 32'hFFFF_FFFF);
  assign div_hold = div_enable && (dcnt < (fast ? 6'd1 : 6'd35));

  function automatic logic [31:0] model_q(input logic [31:0] a, b, input logic s);
    if (b == 32'd0) return 32'hFFFF_FFFF;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
    if (s) return $signed(a) / $signed(b);
    return a / b;
  endfunction

  function automatic logic [31:0] model_r(input logic [31:0] a, b, input logic s);
    if (b == 32'd0) return a;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
    if (s) return $signed(a) % $signed(b);
    return a % b;
  endfunction

  // Garbage while busy so an early capture is visible in the data.
  assign div_quo = div_hold ? 32'hDEAD_BEEF : model_q(div_a, div_b, div_signed);
  assign div_rem = div_hold ? 32'hBAD0_F00D : model_r(div_a, div_b, div_signed);

  logic        prev_en = 1'b0;
  logic [64:0] prev_ops = '0;
  always @(posedge clk) begin
    if (div_enable) en_cnt = en_cnt + 1;
    if (div_enable && prev_en && ({div_signed, div_a, div_b} !== prev_ops)) begin
      stab_errs = stab_errs + 1;
    end
    prev_en  = div_enable;
    prev_ops = {div_signed, div_a, div_b};
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat, output logic [31:0] d);
    lat = -1;
    d   = '0;
    for (int k = 1; k <= 60; k++) begin
      if (resp_valid) begin
        lat = k;
        d   = resp_data;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic take();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({req_ready, resp_valid, div_enable, div_signed} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 1000", {req_ready, resp_valid, div_enable, div_signed});
    end
    vectors++;
    if ({resp_data, div_a, div_b} !== 96'd0) begin
      miscompares++;
      $display("FAIL reset_data got %h %h %h want zeros", resp_data, div_a, div_b);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_div_then_rem_hit();
    int lat; logic [31:0] d; int e0;
    issue(2'b00, 32'd100, 32'd7);
    wait_resp(lat, d);
    vectors++;
    if (lat !== 37 || d !== 32'd14) begin
      miscompares++;
      $display("FAIL div_100_7 got lat=%0d data=%h want lat=37 data=0000000e", lat, d);
    end
    take();
    e0 = en_cnt;
    issue(2'b10, 32'd100, 32'd7);
    wait_resp(lat, d);
    vectors++;
    if (lat !== 1 || d !== 32'd2) begin
      miscompares++;
      $display("FAIL rem_hit_100_7 got lat=%0d data=%h want lat=1 data=00000002", lat, d);
    end
    vectors++;
    if (en_cnt !== e0) begin
      miscompares++;
      $display("FAIL hit_no_enable got %0d enable cycles want 0", en_cnt - e0);
    end
    take();
  endtask

  task automatic test_signed();
    int lat; logic [31:0] d;
    issue(2'b00, 32'hFFFF_FFF9, 32'd2);
    wait_resp(lat, d);
    vectors++;
    if (lat !== 37 || d !== 32'hFFFF_FFFD) begin
      miscompares++;
      $display("FAIL div_m7_2 got lat=%0d data=%h want lat=37 data=fffffffd", lat, d);
    end
    take();
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_resp(lat, d);
    vectors++;
    if (lat !== 1 || d !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL rem_m7_2 got lat=%0d data=%h want lat=1 data=ffffffff", lat, d);
    end
    take();
  endtask

  task automatic test_special();
    int lat; logic [31:0] d;
    issue(2'b01, 32'd5, 32'd0);
    wait_resp(lat, d);
    vectors++;
    if (lat !== 3 || d !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL divu_by0 got lat=%0d data=%h want lat=3 data=ffffffff", lat, d);
    end
    take();
    issue(2'b11, 32'd5, 32'd0);
    wait_resp(lat, d);
    vectors++;
    if (lat !== 1 || d !== 32'd5) begin
      miscompares++;
      $display("FAIL remu_by0 got lat=%0d data=%h want lat=1 data=00000005", lat, d);
    end
    take();
    issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_resp(lat, d);
    vectors++;
    if (lat !== 3 || d !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL div_ovf got lat=%0d data=%h want lat=3 data=80000000", lat, d);
    end
    take();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_resp(lat, d);
    vectors++;
    if (lat !== 1 || d !== 32'd0) begin
      miscompares++;
      $display("FAIL rem_ovf got lat=%0d data=%h want lat=1 data=00000000", lat, d);
    end
    take();
  endtask

  task automatic test_flush();
    int lat; logic [31:0] d; int e0; int first_ready; logic saw_valid;
    first_ready = -1;
    saw_valid   = 1'b0;
    issue(2'b00, 32'd1000, 32'd3);
    for (int k = 1; k <= 40; k++) begin
      flush = (k == 10);
      if (resp_valid) saw_valid = 1'b1;
      if (req_ready && first_ready < 0) first_ready = k;
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    vectors++;
    if (saw_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_no_resp got resp_valid=1 want 0");
    end
    vectors++;
    if (first_ready !== 37) begin
      miscompares++;
      $display("FAIL flush_ready_cycle got %0d want 37", first_ready);
    end
    e0 = en_cnt;
    issue(2'b10, 32'd1000, 32'd3);
    wait_resp(lat, d);
    vectors++;
    if (lat !== 1 || d !== 32'd1 || en_cnt !== e0) begin
      miscompares++;
      $display("FAIL flush_fills_cache got lat=%0d data=%h en=%0d want lat=1 data=00000001 en=0",
               lat, d, en_cnt - e0);
    end
    take();
  endtask

  task automatic test_stall();
    int lat; logic [31:0] d;
    issue(2'b01, 32'hFFFF_FFFF, 32'd16);
    wait_resp(lat, d);
    vectors++;
    if (lat !== 37 || d !== 32'h0FFF_FFFF) begin
      miscompares++;
      $display("FAIL divu_ffff_16 got lat=%0d data=%h want lat=37 data=0fffffff", lat, d);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      vectors++;
      if ({resp_valid, req_ready, div_enable} !== 3'b100 || resp_data !== 32'h0FFF_FFFF) begin
        miscompares++;
        $display("FAIL stall_%0d got v/r/en=%b data=%h want 100 data=0fffffff",
                 i, {resp_valid, req_ready, div_enable}, resp_data);
      end
    end
    take();
    issue(2'b11, 32'd1234567, 32'd1000);
    wait_resp(lat, d);
    vectors++;
    if (lat !== 37 || d !== 32'd567) begin
      miscompares++;
      $display("FAIL remu_after_stall got lat=%0d data=%h want lat=37 data=00000237", lat, d);
    end
    take();
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] d; int e0;
    issue(2'b00, 32'd50, 32'd5);
    wait_resp(lat, d);
    vectors++;
    if (lat !== 37 || d !== 32'd10) begin
      miscompares++;
      $display("FAIL div_50_5 got lat=%0d data=%h want lat=37 data=0000000a", lat, d);
    end
    take();
    issue(2'b01, 32'd60, 32'd7);
    repeat (19) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({req_ready, resp_valid, div_enable, div_signed} !== 4'b1000) begin
      miscompares++;
      $display("FAIL midreset_ctrl got %b want 1000", {req_ready, resp_valid, div_enable, div_signed});
    end
    vectors++;
    if ({resp_data, div_a, div_b} !== 96'd0) begin
      miscompares++;
      $display("FAIL midreset_data got %h %h %h want zeros", resp_data, div_a, div_b);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    e0 = en_cnt;
    issue(2'b00, 32'd50, 32'd5);
    wait_resp(lat, d);
    vectors++;
    if (lat !== 37 || d !== 32'd10 || en_cnt === e0) begin
      miscompares++;
      $display("FAIL cache_cleared got lat=%0d data=%h en=%0d want lat=37 data=0000000a en>0",
               lat, d, en_cnt - e0);
    end
    take();
  endtask

  task automatic test_operand_hold();
    vectors++;
    if (stab_errs !== 0) begin
      miscompares++;
      $display("FAIL operand_hold got %0d changes while enabled want 0", stab_errs);
    end
  endtask

  initial begin
    test_reset();
    test_div_then_rem_hit();
    test_signed();
    test_special();
    test_flush();
    test_stall();
    test_reset_mid();
    test_operand_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
